int_sequencer: RTL and testbench
================================

Name: int_sequencer

Overview:
- Interrupt/reset sequencer directly upstream of the CPU control unit.
- Synchronizes the external nmi_n and irq_n pins and latches NMI edges.
- Arbitrates reset, NMI and IRQ at instruction-fetch boundaries.
- While an interrupt is being serviced, forces the control unit to execute an injected BRK (opcode 0x00) and supplies the vector address and the B value for the stacked P.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the nmi_n/irq_n synchronizers (minimum 2).
- VEC_NMI, 16'hFFFA, NMI vector address.
- VEC_RES, 16'hFFFC, reset vector address.
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- nmi_n  in  1  external NMI pin, asynchronous; falling edge triggers.
- irq_n  in  1  external IRQ pin, asynchronous; level-low triggers.
- P_I  in  1  I flag from the P register (1 = IRQ masked).
- fetch_stb  in  1  from control: current cycle is an opcode-fetch boundary (poll point).
- vec_stb  in  1  from control: vector low-byte fetch is happening this cycle.
- force_brk  out  1  selects the injected 0x00 into IR in place of memory data.
- int_kind  out  2  00 none, 01 reset, 10 NMI, 11 IRQ.
- vec_addr  out  16  vector address for the current or next vector fetch.
- b_flag  out  1  value of B to push with P.
- nmi_pend  out  1  NMI latch state, for debug/visibility.

Behaviour:
- Reset: asynchronous, active-low, on rst_n. While rst_n=0:
  - all synchronizer flops = 1 (inactive), nmi latch = 0, res_pend = 1;
  - state = IDLE, force_brk = 0, int_kind = 00, vec_addr = VEC_IRQ, b_flag = 1, nmi_pend = 0.
- Synchronization: nmi_n and irq_n each pass through SYNC_STAGES flops.
  - The NMI edge detector compares the last sync stage with one extra registered copy.
  - A detected 1->0 transition sets the nmi latch on the following clock edge.
- IRQ is never latched. irq_req = (synchronized irq_n == 0) && !P_I, evaluated only at the poll.
- Priority at poll: res_pend > nmi latch > irq_req.
- States:
  - IDLE: force_brk = 0, int_kind = 00, vec_addr = VEC_IRQ (serves software BRK), b_flag = 1.
    - If fetch_stb and any request is pending: on that clock edge capture the winning kind into kind_q and go to SERVICE.
    - Otherwise remain in IDLE.
  - SERVICE: force_brk = 1, int_kind = kind_q, b_flag = 0, vec_addr = vector for kind_q.
    - fetch_stb is ignored.
    - On vec_stb: return to IDLE. If kind_q = NMI, clear the nmi latch. If kind_q = reset, clear res_pend.
- Latency: a pending request seen at fetch_stb in cycle N gives force_brk = 1 in cycle N+1. NMI pin to latch = SYNC_STAGES+1 cycles.
- IRQ deasserting (or P_I rising) while in SERVICE does not abort; the sequence completes with VEC_IRQ.
- Simultaneous events:
  - A new NMI edge detected in the same cycle vec_stb clears the latch: the set wins and the latch stays 1.
  - fetch_stb and vec_stb together in IDLE: vec_stb is ignored.
- Reset mid-SERVICE: immediate return to IDLE with res_pend = 1. Any latched NMI is lost.
- vec_stb in IDLE (software BRK): no state change, no latch cleared.

Optional Feature:
- Macro: NMI_HIJACK_EN.
- Defined: in SERVICE with kind_q = IRQ, if the nmi latch is 1 at vec_stb, the vector is VEC_NMI (vec_addr switches combinationally as soon as the latch sets). The nmi latch is cleared; int_kind reports 10 from that point.
- Undefined: vector and kind are fixed at SERVICE entry. The NMI stays latched and is taken at the next fetch_stb.

Test Plan:
- Release rst_n, first fetch_stb -> next cycle force_brk = 1, int_kind = 01, vec_addr = 16'hFFFC. vec_stb -> IDLE, res_pend cleared, vec_addr = 16'hFFFE.
- irq_n = 0, P_I = 1, repeated fetch_stb -> force_brk stays 0. Set P_I = 0, then fetch_stb -> int_kind = 11, vec_addr = 16'hFFFE, b_flag = 0.
- Single nmi_n low pulse of 1 cycle, then pin held high -> nmi_pend = 1 after 3 cycles. fetch_stb -> vec_addr = 16'hFFFA. vec_stb -> nmi_pend = 0.
- irq_n = 0 and an nmi_n edge both pending at fetch_stb -> int_kind = 10. After vec_stb with irq_n still low, next fetch_stb -> int_kind = 11.
- Enter SERVICE for IRQ, then an nmi_n edge before vec_stb -> with NMI_HIJACK_EN: vec_addr = 16'hFFFA and nmi_pend cleared at vec_stb. Without: vec_addr = 16'hFFFE, nmi_pend stays 1, next fetch_stb -> int_kind = 10.
- Assert rst_n = 0 mid-SERVICE -> outputs go to reset values the same cycle. After release, fetch_stb -> int_kind = 01.

Source files
------------

// File: rtl/int_sequencer.sv
// ---------------------------------------------------------------------------
// int_sequencer
//
// Interrupt/reset sequencer sitting directly in front of the CPU control
// unit. It synchronizes the external NMI/IRQ pins and latches NMI falling
// edges. At each opcode-fetch boundary it arbitrates reset > NMI > IRQ.
// While a request is being serviced it forces the control unit to execute an
// injected BRK (opcode 0x00). It also supplies the vector address and the B
// flag value to be stacked with P.
//
// Optional build macro: NMI_HIJACK_EN
//   defined   - an NMI latched while an IRQ is in service redirects the vector
//               fetch to VEC_NMI and is consumed by that fetch.
//   undefined - vector and kind are frozen at service entry. A late NMI stays
//               latched and is taken at the next fetch boundary.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   nmi_n      in   external NMI pin (async), falling edge triggers
//   irq_n      in   external IRQ pin (async), low level triggers
//   P_I        in   I flag from P (1 = IRQ masked)
//   fetch_stb  in   current cycle is an opcode-fetch boundary (poll point)
//   vec_stb    in   vector low-byte fetch happens this cycle
//   force_brk  out  inject 0x00 into IR instead of memory data
//   int_kind   out  00 none, 01 reset, 10 NMI, 11 IRQ
//   vec_addr   out  vector address for the current/next vector fetch
//   b_flag     out  value of B to push with P
//   nmi_pend   out  NMI latch state (debug visibility)
// ---------------------------------------------------------------------------
module int_sequencer #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] VEC_NMI     = 16'hFFFA,
    parameter logic [15:0] VEC_RES     = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ     = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        P_I,
    input  logic        fetch_stb,
    input  logic        vec_stb,
    output logic        force_brk,
    output logic [1:0]  int_kind,
    output logic [15:0] vec_addr,
    output logic        b_flag,
    output logic        nmi_pend
);

    // A synchronizer shallower than two flops is not safe, so clamp the depth.
    localparam int SN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [1:0] K_NONE = 2'b00;
    localparam logic [1:0] K_RES  = 2'b01;
    localparam logic [1:0] K_NMI  = 2'b10;
    localparam logic [1:0] K_IRQ  = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_SERVICE
    } state_t;

    logic [SN-1:0] nmi_sync_q;
    logic [SN-1:0] irq_sync_q;
    logic          nmi_prev_q;
    logic          nmi_q, nmi_d;
    logic          res_pend_q, res_pend_d;
    state_t        state_q, state_d;
    logic [1:0]    kind_q, kind_d;

    logic          nmi_fall;
    logic          irq_req;
    logic          nmi_clr;
    logic [1:0]    eff_kind;

    function automatic logic [15:0] vec_for(input logic [1:0] k);
        case (k)
            K_RES:   vec_for = VEC_RES;
            K_NMI:   vec_for = VEC_NMI;
            default: vec_for = VEC_IRQ;
        endcase
    endfunction

    // Pin synchronizers. Reset value 1 means "pin inactive" for both lines.
    // nmi_prev_q is the extra copy used to detect a 1->0 transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_sync_q <= '1;
            irq_sync_q <= '1;
            nmi_prev_q <= 1'b1;
        end else begin
            nmi_sync_q <= {nmi_sync_q[SN-2:0], nmi_n};
            irq_sync_q <= {irq_sync_q[SN-2:0], irq_n};
            nmi_prev_q <= nmi_sync_q[SN-1];
        end
    end

    assign nmi_fall = nmi_prev_q & ~nmi_sync_q[SN-1];
    // IRQ is level-sensitive and never stored; it only matters at the poll.
    assign irq_req  = ~irq_sync_q[SN-1] & ~P_I;

`ifdef NMI_HIJACK_EN
    // An NMI arriving during IRQ service takes over the pending vector fetch.
    assign eff_kind = (state_q == ST_SERVICE && kind_q == K_IRQ && nmi_q) ? K_NMI : kind_q;
`else
    assign eff_kind = kind_q;
`endif

    // Control state and latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            kind_q     <= K_NONE;
            nmi_q      <= 1'b0;
            res_pend_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            nmi_q      <= nmi_d;
            res_pend_q <= res_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        res_pend_d = res_pend_q;
        nmi_clr    = 1'b0;
        force_brk  = 1'b0;
        int_kind   = K_NONE;
        vec_addr   = VEC_IRQ;   // idle value also serves a software BRK
        b_flag     = 1'b1;

        case (state_q)
            ST_IDLE: begin
                // vec_stb here is a software BRK and is deliberately ignored.
                if (fetch_stb && (res_pend_q || nmi_q || irq_req)) begin
                    state_d = ST_SERVICE;
                    if (res_pend_q)  kind_d = K_RES;
                    else if (nmi_q)  kind_d = K_NMI;
                    else             kind_d = K_IRQ;
                end
            end
            ST_SERVICE: begin
                force_brk = 1'b1;
                int_kind  = eff_kind;
                b_flag    = 1'b0;
                vec_addr  = vec_for(eff_kind);
                if (vec_stb) begin
                    state_d = ST_IDLE;
                    if (eff_kind == K_NMI) nmi_clr    = 1'b1;
                    if (eff_kind == K_RES) res_pend_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fresh edge in the same cycle as the clear keeps the latch set.
    assign nmi_d    = nmi_fall ? 1'b1 : (nmi_clr ? 1'b0 : nmi_q);
    assign nmi_pend = nmi_q;

endmodule

// File: tb/tb_int_sequencer.sv
module tb_int_sequencer;

    localparam int          SYNC_STAGES = 2;
    localparam logic [15:0] VEC_NMI     = 16'hFFFA;
    localparam logic [15:0] VEC_RES     = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ     = 16'hFFFE;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        nmi_n     = 1'b1;
    logic        irq_n     = 1'b1;
    logic        P_I       = 1'b1;
    logic        fetch_stb = 1'b0;
    logic        vec_stb   = 1'b0;
    logic        force_brk;
    logic [1:0]  int_kind;
    logic [15:0] vec_addr;
    logic        b_flag;
    logic        nmi_pend;

    int errors = 0;
    int checks = 0;

    int_sequencer #(
        .SYNC_STAGES(SYNC_STAGES),
        .VEC_NMI(VEC_NMI),
        .VEC_RES(VEC_RES),
        .VEC_IRQ(VEC_IRQ)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .nmi_n(nmi_n),
        .irq_n(irq_n),
        .P_I(P_I),
        .fetch_stb(fetch_stb),
        .vec_stb(vec_stb),
        .force_brk(force_brk),
        .int_kind(int_kind),
        .vec_addr(vec_addr),
        .b_flag(b_flag),
        .nmi_pend(nmi_pend)
    );

    always #5 clk = ~clk;

    // Reference model: pin history queues plus plain booleans for the
    // pending reset, NMI latch and "servicing kind k".
    bit qn[$];   // qn[i] = nmi pin as sampled i+1 edges ago
    bit qi[$];
    bit m_nmi, m_res, m_busy;
    int m_kind;

    function automatic int eff_kind();
`ifdef NMI_HIJACK_EN
        if (m_busy && m_kind == 3 && m_nmi) return 2;
`endif
        return m_kind;
    endfunction

    function automatic logic [15:0] vec_of(input int k);
        if (k == 1) return VEC_RES;
        if (k == 2) return VEC_NMI;
        return VEC_IRQ;
    endfunction

    task automatic model_reset();
        qn.delete();
        qi.delete();
        for (int i = 0; i < SYNC_STAGES + 1; i++) qn.push_back(1'b1);
        for (int i = 0; i < SYNC_STAGES; i++) qi.push_back(1'b1);
        m_nmi  = 1'b0;
        m_res  = 1'b1;
        m_busy = 1'b0;
        m_kind = 0;
    endtask

    task automatic model_edge();
        bit fell, req, clr;
        int ek;
        if (!rst_n) begin
            model_reset();
            return;
        end
        fell = qn[SYNC_STAGES] && !qn[SYNC_STAGES-1];
        req  = !qi[SYNC_STAGES-1] && !P_I;
        clr  = 1'b0;
        ek   = eff_kind();
        if (!m_busy) begin
            if (fetch_stb && (m_res || m_nmi || req)) begin
                m_busy = 1'b1;
                m_kind = m_res ? 1 : (m_nmi ? 2 : 3);
            end
        end else if (vec_stb) begin
            m_busy = 1'b0;
            if (ek == 2) clr = 1'b1;
            if (ek == 1) m_res = 1'b0;
        end
        if (fell) m_nmi = 1'b1;
        else if (clr) m_nmi = 1'b0;
        qn.push_front(nmi_n);
        void'(qn.pop_back());
        qi.push_front(irq_n);
        void'(qi.pop_back());
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int ek;
        ek = eff_kind();
        chk({tag, ".force_brk"}, 32'(force_brk), 32'(m_busy));
        chk({tag, ".int_kind"},  32'(int_kind),  m_busy ? 32'(ek) : 32'd0);
        chk({tag, ".vec_addr"},  32'(vec_addr),  m_busy ? 32'(vec_of(ek)) : 32'(VEC_IRQ));
        chk({tag, ".b_flag"},    32'(b_flag),    32'(!m_busy));
        chk({tag, ".nmi_pend"},  32'(nmi_pend),  32'(m_nmi));
    endtask

    // One clock: the model consumes the inputs present before the edge, then
    // outputs are compared shortly after the edge.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #2;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst.force_brk", 32'(force_brk), 32'd0);
        chk("rst.int_kind",  32'(int_kind),  32'd0);
        chk("rst.vec_addr",  32'(vec_addr),  32'hFFFE);
        chk("rst.b_flag",    32'(b_flag),    32'd1);
        chk("rst.nmi_pend",  32'(nmi_pend),  32'd0);
        tick("rst_hold");
        tick("rst_hold");

        // Reset vector sequence
        rst_n = 1'b1;
        tick("post_rst");
        fetch_stb = 1'b1;
        tick("res_fetch");
        chk("res.force_brk", 32'(force_brk), 32'd1);
        chk("res.int_kind",  32'(int_kind),  32'h1);
        chk("res.vec_addr",  32'(vec_addr),  32'hFFFC);
        fetch_stb = 1'b0;
        tick("res_wait");
        vec_stb = 1'b1;
        tick("res_vec");
        chk("res_done.force_brk", 32'(force_brk), 32'd0);
        chk("res_done.vec_addr",  32'(vec_addr),  32'hFFFE);
        vec_stb = 1'b0;

        // Masked IRQ, then unmasked
        irq_n = 1'b0;
        P_I   = 1'b1;
        tick("irq_sync");
        tick("irq_sync");
        tick("irq_sync");
        fetch_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("irq_masked");
            chk("irq_masked.force_brk", 32'(force_brk), 32'd0);
        end
        fetch_stb = 1'b0;
        P_I = 1'b0;
        tick("irq_unmask");
        fetch_stb = 1'b1;
        tick("irq_fetch");
        chk("irq.int_kind", 32'(int_kind), 32'h3);
        chk("irq.vec_addr", 32'(vec_addr), 32'hFFFE);
        chk("irq.b_flag",   32'(b_flag),   32'd0);
        fetch_stb = 1'b0;
        vec_stb   = 1'b1;
        tick("irq_vec");
        vec_stb = 1'b0;
        irq_n   = 1'b1;
        tick("irq_rel");
        tick("irq_rel");
        tick("irq_rel");

        // One-cycle NMI pulse: latch appears after SYNC_STAGES+1 edges
        nmi_n = 1'b0;
        tick("nmi_e1");
        nmi_n = 1'b1;
        tick("nmi_e2");
        chk("nmi_lat_early", 32'(nmi_pend), 32'd0);
        tick("nmi_e3");
        chk("nmi_lat", 32'(nmi_pend), 32'd1);
        fetch_stb = 1'b1;
        tick("nmi_fetch");
        chk("nmi.vec_addr", 32'(vec_addr), 32'hFFFA);
        chk("nmi.int_kind", 32'(int_kind), 32'h2);
        fetch_stb = 1'b0;
        vec_stb   = 1'b1;
        tick("nmi_vec");
        chk("nmi_clr", 32'(nmi_pend), 32'd0);
        vec_stb = 1'b0;

        // NMI beats IRQ; IRQ follows once NMI is done
        irq_n = 1'b0;
        nmi_n = 1'b0;
        tick("both_sync");
        tick("both_sync");
        tick("both_sync");
        nmi_n = 1'b1;
        fetch_stb = 1'b1;
        tick("both_fetch");
        chk("prio.int_kind", 32'(int_kind), 32'h2);
        fetch_stb = 1'b0;
        vec_stb   = 1'b1;
        tick("both_vec");
        vec_stb   = 1'b0;
        fetch_stb = 1'b1;
        tick("irq_after");
        chk("irq_after.int_kind", 32'(int_kind), 32'h3);

        // NMI arriving during IRQ service
        fetch_stb = 1'b0;
        nmi_n = 1'b0;
        tick("hj_e1");
        nmi_n = 1'b1;
        tick("hj_e2");
        tick("hj_e3");
        chk("hj.nmi_pend", 32'(nmi_pend), 32'd1);
`ifdef NMI_HIJACK_EN
        chk("hj.vec_addr", 32'(vec_addr), 32'hFFFA);
        chk("hj.int_kind", 32'(int_kind), 32'h2);
`else
        chk("hj.vec_addr", 32'(vec_addr), 32'hFFFE);
        chk("hj.int_kind", 32'(int_kind), 32'h3);
`endif
        vec_stb = 1'b1;
        tick("hj_vec");
        vec_stb = 1'b0;
        irq_n   = 1'b1;
        P_I     = 1'b1;
`ifdef NMI_HIJACK_EN
        chk("hj_vec.nmi_pend", 32'(nmi_pend), 32'd0);
`else
        chk("hj_vec.nmi_pend", 32'(nmi_pend), 32'd1);
`endif
        fetch_stb = 1'b1;
        tick("hj_next");
`ifdef NMI_HIJACK_EN
        chk("hj_next.force_brk", 32'(force_brk), 32'd0);
`else
        chk("hj_next.int_kind", 32'(int_kind), 32'h2);
`endif
        fetch_stb = 1'b0;
        vec_stb   = 1'b1;
        tick("hj_done");
        vec_stb = 1'b0;
        tick("hj_idle");

        // Reset asserted mid-service
        irq_n = 1'b0;
        P_I   = 1'b0;
        tick("mr_sync");
        tick("mr_sync");
        fetch_stb = 1'b1;
        tick("mr_fetch");
        fetch_stb = 1'b0;
        nmi_n = 1'b0;
        tick("mr_nmi");
        nmi_n = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mr.force_brk", 32'(force_brk), 32'd0);
        chk("mr.int_kind",  32'(int_kind),  32'd0);
        chk("mr.vec_addr",  32'(vec_addr),  32'hFFFE);
        chk("mr.b_flag",    32'(b_flag),    32'd1);
        check_outputs("mr_model");
        tick("mr_hold");
        rst_n = 1'b1;
        irq_n = 1'b1;
        tick("mr_rel");
        fetch_stb = 1'b1;
        tick("mr_fetch2");
        chk("mr2.int_kind", 32'(int_kind), 32'h1);
        fetch_stb = 1'b0;
        vec_stb   = 1'b1;
        tick("mr_vec");
        vec_stb = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            fetch_stb = ($urandom_range(0, 2) == 0);
            vec_stb   = ($urandom_range(0, 3) == 0);
            P_I       = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 5) == 0) irq_n = ~irq_n;
            if ($urandom_range(0, 4) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(0, 120) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_outputs("rnd_async_rst");
                tick("rnd_rst_hold");
                rst_n = 1'b1;
            end
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
